// File: rtl/bp_l15_responder_model_if.sv
// Transducer <-> L1.5 request/response bundle. Request: val is held by the requester until ack, and ack is
// combinational in the accept cycle. Response: l15 val stays high with stable data until the cycle with req_ack=1.
interface bp_l15_responder_model_if;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic        transducer_l15_nc;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic [1:0]  transducer_l15_l1rplway;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;
  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic        transducer_l15_req_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_l1rplway, transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_l1rplway, transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
  );
endinterface

// File: rtl/bp_l15_responder_model.sv
// Single-requester L1.5 responder: INT_RET after reset, then loads/stores against a 128-bit-line store.
// The backing store has no reset so its contents survive reset pulses.
module bp_l15_responder_model #(
  parameter int mem_els_p    = 256,
  parameter int init_delay_p = 4,
  parameter int resp_delay_p = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bp_l15_responder_model_if.slave       l15_if,
  output logic                          err_o,
  output logic [15:0]                   load_cnt_o,
  output logic [15:0]                   store_cnt_o,
  output logic [1:0]                    state_o
);
  localparam int IDX_W = $clog2(mem_els_p);

  localparam logic [1:0] E_INIT  = 2'd0;
  localparam logic [1:0] E_READY = 2'd1;
  localparam logic [1:0] E_WAIT  = 2'd2;
  localparam logic [1:0] E_RESP  = 2'd3;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  logic [1:0]   state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   rtype_q, rtype_d;
  logic [127:0] rdata_q, rdata_d;
  logic         err_q, err_d;
  logic [15:0]  ld_q, ld_d, st_q, st_d;
  logic         ack;

  logic [127:0]     mem [mem_els_p];
  logic [IDX_W-1:0] idx;
  logic [3:0]       off;
  logic [4:0]       nbytes;
  logic             size_ok, is_load, is_store, store_ok, accept, wr_en;
  logic [127:0]     wmask, wline;

  assign idx      = l15_if.transducer_l15_address[4 +: IDX_W];
  assign off      = l15_if.transducer_l15_address[3:0];
  assign is_load  = (l15_if.transducer_l15_rqtype == LOAD_RQ);
  assign is_store = (l15_if.transducer_l15_rqtype == STORE_RQ);
  assign accept   = (state_q == E_READY) && l15_if.transducer_l15_val;

  always_comb begin
    nbytes  = 5'd0;
    size_ok = 1'b1;
    case (l15_if.transducer_l15_size)
      3'b000:  nbytes = 5'd1;
      3'b001:  nbytes = 5'd2;
      3'b010:  nbytes = 5'd4;
      3'b011:  nbytes = 5'd8;
      3'b111:  nbytes = 5'd16;
      default: size_ok = 1'b0;
    endcase
  end

  // A store is legal only for 1..8 bytes naturally aligned inside the line.
  assign store_ok = size_ok && (nbytes != 5'd16) && (({1'b0, off} & (nbytes - 5'd1)) == 5'd0);
  assign wr_en    = accept && is_store && store_ok;
  assign wline    = {l15_if.transducer_l15_data, l15_if.transducer_l15_data};

  always_comb begin
    wmask = '0;
    for (int k = 0; k < 16; k++) begin
      if ((5'(k) >= {1'b0, off}) && (5'(k) < ({1'b0, off} + nbytes)))
        wmask[k*8 +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= (mem[idx] & ~wmask) | (wline & wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rtype_d = rtype_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ld_d    = ld_q;
    st_d    = st_q;
    ack     = 1'b0;
    case (state_q)
      E_INIT: begin
        if ((cnt_q + 32'd1) >= 32'(init_delay_p)) begin
          state_d = E_RESP;
          cnt_d   = '0;
          rtype_d = INT_RET;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      E_READY: begin
        if (l15_if.transducer_l15_val) begin
          ack = 1'b1;
          if (!size_ok) err_d = 1'b1;
          if (is_load || is_store) begin
            rtype_d = is_load ? LOAD_RET : ST_ACK;
            rdata_d = is_load ? mem[idx] : '0;
            if (is_store && !store_ok) err_d = 1'b1;
            state_d = (resp_delay_p <= 1) ? E_RESP : E_WAIT;
            cnt_d   = 32'd1;
          end else begin
            // Unknown request types are swallowed without a response.
            err_d = 1'b1;
          end
        end
      end
      E_WAIT: begin
        if (cnt_q >= 32'(resp_delay_p - 1)) state_d = E_RESP;
        else cnt_d = cnt_q + 32'd1;
      end
      E_RESP: begin
        if (l15_if.transducer_l15_req_ack) begin
          state_d = E_READY;
          if (rtype_q == LOAD_RET && ld_q != 16'hFFFF) ld_d = ld_q + 16'd1;
          if (rtype_q == ST_ACK && st_q != 16'hFFFF) st_d = st_q + 16'd1;
        end
      end
      default: state_d = E_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= E_INIT;
      cnt_q   <= '0;
      rtype_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rtype_q <= rtype_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
    end
  end

  assign l15_if.l15_transducer_ack        = ack;
  assign l15_if.l15_transducer_header_ack = 1'b0;
  assign l15_if.l15_transducer_val        = (state_q == E_RESP);
  assign l15_if.l15_transducer_returntype = rtype_q;
  assign l15_if.l15_transducer_data_0     = rdata_q[63:0];
  assign l15_if.l15_transducer_data_1     = rdata_q[127:64];
  assign err_o       = err_q;
  assign load_cnt_o  = ld_q;
  assign store_cnt_o = st_q;
  assign state_o     = state_q;

  logic unused_ok;
  assign unused_ok = ^{l15_if.transducer_l15_nc, l15_if.transducer_l15_l1rplway,
                       l15_if.transducer_l15_address[39:4+IDX_W]};
endmodule

// File: tb/tb_bp_l15_responder_model.sv
// Bench for bp_l15_responder_model: byte-level reference memory, expected-response queues, directed and random traffic.
module tb_bp_l15_responder_model;
  localparam int MEM_ELS    = 256;
  localparam int INIT_DELAY = 4;
  localparam int RESP_DELAY = 2;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_l15_responder_model_if bus();
  logic        err;
  logic [15:0] lc, sc;
  logic [1:0]  dbg_state;

  bp_l15_responder_model #(.mem_els_p(MEM_ELS), .init_delay_p(INIT_DELAY), .resp_delay_p(RESP_DELAY)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .l15_if(bus), .err_o(err),
    .load_cnt_o(lc), .store_cnt_o(sc), .state_o(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte array with a known-byte map (store contents start undefined).
  logic [7:0]   mref   [MEM_ELS][16];
  bit           mknown [MEM_ELS][16];
  logic         exp_err = 1'b0;
  int           exp_ld = 0, exp_st = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_mask_q[$];
  logic [3:0]   exp_type_q[$];

  task automatic ref_req(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] a,
                         input logic [63:0] d, output bit resp);
    int idx = int'((longint'(a) >> 4) % MEM_ELS);
    int o = int'(a[3:0]);
    int n;
    bit szok = 1'b1;
    logic [127:0] line = '0, mask = '0;
    case (sz)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd3: n = 8;
      3'd7: n = 16;
      default: begin n = 0; szok = 1'b0; end
    endcase
    if (!szok) exp_err = 1'b1;
    resp = 1'b1;
    if (rq == LOAD_RQ) begin
      for (int k = 0; k < 16; k++) begin
        line[k*8 +: 8] = mref[idx][k];
        mask[k*8 +: 8] = mknown[idx][k] ? 8'hFF : 8'h00;
      end
      exp_type_q.push_back(LOAD_RET); exp_q.push_back(line); exp_mask_q.push_back(mask);
    end else if (rq == STORE_RQ) begin
      if (!szok || n == 16 || (o % n) != 0) exp_err = 1'b1;
      else begin
        for (int k = o; k < o + n; k++) begin
          mref[idx][k]   = d[(k % 8)*8 +: 8];
          mknown[idx][k] = 1'b1;
        end
      end
      exp_type_q.push_back(ST_ACK); exp_q.push_back('0); exp_mask_q.push_back({128{1'b1}});
    end else begin
      exp_err = 1'b1;
      resp = 1'b0;
    end
  endtask

  task automatic send_req(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] a,
                          input logic [63:0] d, output bit ok);
    int w = 0;
    @(negedge clk);
    bus.transducer_l15_rqtype  = rq;
    bus.transducer_l15_size    = sz;
    bus.transducer_l15_address = a;
    bus.transducer_l15_data    = d;
    bus.transducer_l15_nc      = $urandom_range(0, 1) == 1;
    bus.transducer_l15_val     = 1'b1;
    #1;
    while (bus.l15_transducer_ack !== 1'b1 && w < 50) begin
      @(negedge clk); #1; w++;
    end
    n_tests++;
    ok = (bus.l15_transducer_ack === 1'b1);
    if (!ok) begin
      n_fail++;
      $display("FAIL ack_timeout: ack=%b after %0d cycles, required 1", bus.l15_transducer_ack, w);
      bus.transducer_l15_val = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.transducer_l15_val = 1'b0;
  endtask

  task automatic wait_resp(input int start, input int lat, output logic [3:0] et,
                           output logic [127:0] ed, output logic [127:0] em);
    int cyc = start;
    et = exp_type_q.pop_front(); ed = exp_q.pop_front(); em = exp_mask_q.pop_front();
    bus.transducer_l15_val = 1'b1;
    #1;
    while (bus.l15_transducer_val !== 1'b1 && cyc < 50) begin
      n_tests++;
      if (bus.l15_transducer_ack !== 1'b0) begin
        n_fail++; $display("FAIL ack_while_busy: ack=%b required 0", bus.l15_transducer_ack);
      end
      @(posedge clk); @(negedge clk); #1; cyc++;
    end
    bus.transducer_l15_val = 1'b0;
    n_tests++;
    if (cyc != lat) begin
      n_fail++; $display("FAIL resp_latency: got %0d cycles, required %0d", cyc, lat);
    end
    n_tests++;
    if (bus.l15_transducer_returntype !== et) begin
      n_fail++; $display("FAIL returntype: got %h required %h", bus.l15_transducer_returntype, et);
    end
    n_tests++;
    if (({bus.l15_transducer_data_1, bus.l15_transducer_data_0} & em) !== (ed & em)) begin
      n_fail++; $display("FAIL resp_data: got %h required %h (mask %h)",
                         {bus.l15_transducer_data_1, bus.l15_transducer_data_0}, ed, em);
    end
  endtask

  task automatic consume(input int hold, input logic [3:0] et, input logic [127:0] ed, input logic [127:0] em);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      bus.transducer_l15_val = 1'b1;
      #1;
      n_tests++;
      if (bus.l15_transducer_val !== 1'b1 || bus.l15_transducer_ack !== 1'b0 ||
          bus.l15_transducer_returntype !== et ||
          ({bus.l15_transducer_data_1, bus.l15_transducer_data_0} & em) !== (ed & em)) begin
        n_fail++; $display("FAIL resp_hold: val=%b ack=%b type=%h required val=1 ack=0 type=%h",
                           bus.l15_transducer_val, bus.l15_transducer_ack, bus.l15_transducer_returntype, et);
      end
    end
    @(negedge clk);
    bus.transducer_l15_val    = 1'b0;
    bus.transducer_l15_req_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.transducer_l15_req_ack = 1'b0;
    if (et == LOAD_RET) exp_ld = (exp_ld < 65535) ? exp_ld + 1 : 65535;
    if (et == ST_ACK)   exp_st = (exp_st < 65535) ? exp_st + 1 : 65535;
    #1;
    n_tests++;
    if (bus.l15_transducer_val !== 1'b0) begin
      n_fail++; $display("FAIL val_drop: val=%b required 0", bus.l15_transducer_val);
    end
    n_tests++;
    if (lc !== 16'(exp_ld) || sc !== 16'(exp_st) || err !== exp_err) begin
      n_fail++; $display("FAIL counters: load=%0d store=%0d err=%b required load=%0d store=%0d err=%b",
                         lc, sc, err, exp_ld, exp_st, exp_err);
    end
  endtask

  task automatic do_txn(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] a,
                        input logic [63:0] d, input int hold);
    bit resp, ok;
    logic [3:0] et;
    logic [127:0] ed, em;
    ref_req(rq, sz, a, d, resp);
    send_req(rq, sz, a, d, ok);
    if (!ok) begin
      if (resp) begin void'(exp_type_q.pop_back()); void'(exp_q.pop_back()); void'(exp_mask_q.pop_back()); end
      return;
    end
    if (resp) begin
      wait_resp(1, RESP_DELAY, et, ed, em);
      consume(hold, et, ed, em);
    end else begin
      for (int i = 0; i < 3; i++) begin
        #1;
        n_tests++;
        if (bus.l15_transducer_val !== 1'b0) begin
          n_fail++; $display("FAIL bad_rq_no_resp: val=%b required 0", bus.l15_transducer_val);
        end
        @(posedge clk); @(negedge clk);
      end
      n_tests++;
      if (err !== exp_err) begin
        n_fail++; $display("FAIL bad_rq_err: err=%b required %b", err, exp_err);
      end
    end
  endtask

  task automatic take_int(input int hold);
    logic [3:0] et;
    logic [127:0] ed, em;
    exp_type_q.push_back(INT_RET); exp_q.push_back('0); exp_mask_q.push_back({128{1'b1}});
    wait_resp(0, INIT_DELAY, et, ed, em);
    consume(hold, et, ed, em);
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bus.l15_transducer_ack !== 1'b0 || bus.l15_transducer_val !== 1'b0 ||
        bus.l15_transducer_returntype !== 4'h0 || bus.l15_transducer_data_0 !== 64'h0 ||
        bus.l15_transducer_data_1 !== 64'h0 || err !== 1'b0 || lc !== 16'h0 || sc !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs: ack=%b val=%b type=%h err=%b lc=%0d sc=%0d required all 0",
                         bus.l15_transducer_ack, bus.l15_transducer_val, bus.l15_transducer_returntype, err, lc, sc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    take_int(3);
  endtask

  task automatic test_store_load();
    do_txn(STORE_RQ, 3'd3, 40'h100, 64'h1122334455667788, 0);
    do_txn(LOAD_RQ,  3'd3, 40'h100, 64'h0, 0);
    n_tests++;
    if (bus.l15_transducer_data_0 !== 64'h1122334455667788 || lc !== 16'd1 || sc !== 16'd1) begin
      n_fail++; $display("FAIL store_load: data_0=%h lc=%0d sc=%0d required 1122334455667788 1 1",
                         bus.l15_transducer_data_0, lc, sc);
    end
    do_txn(STORE_RQ, 3'd3, 40'h108, 64'hCAFEF00DDEADBEEF, 1);
  endtask

  task automatic test_byte_store();
    do_txn(STORE_RQ, 3'd0, 40'h10B, {8{8'hAB}}, 0);
    do_txn(LOAD_RQ,  3'd4 - 3'd4, 40'h100, 64'h0, 0);
    n_tests++;
    if (bus.l15_transducer_data_1 !== 64'hCAFEF00DABADBEEF) begin
      n_fail++; $display("FAIL byte_store: data_1=%h required cafef00dabadbeef", bus.l15_transducer_data_1);
    end
  endtask

  task automatic test_misaligned();
    do_txn(STORE_RQ, 3'd2, 40'h102, 64'h5555555555555555, 0);
    do_txn(LOAD_RQ,  3'd3, 40'h100, 64'h0, 0);
    do_txn(STORE_RQ, 3'd7, 40'h110, 64'h0, 0);
    do_txn(STORE_RQ, 3'd5, 40'h120, 64'h0, 0);
    do_txn(5'b00110, 3'd3, 40'h130, 64'h0, 0);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_alias_hold();
    do_txn(STORE_RQ, 3'd3, 40'h1000, 64'h0F1E2D3C4B5A6978, 0);
    do_txn(STORE_RQ, 3'd3, 40'h1008, 64'h8796A5B4C3D2E1F0, 0);
    do_txn(LOAD_RQ,  3'd3, 40'h0000, 64'h0, 5);
  endtask

  task automatic test_random();
    logic [2:0] sizes [6];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd4};
    for (int i = 0; i < 8; i++) begin
      do_txn(STORE_RQ, 3'd3, 40'(i*16), {$urandom, $urandom}, 0);
      do_txn(STORE_RQ, 3'd3, 40'(i*16 + 8), {$urandom, $urandom}, 0);
    end
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 19);
      logic [4:0] rq = (r < 9) ? LOAD_RQ : (r < 19) ? STORE_RQ : 5'b01010;
      logic [2:0] sz = ($urandom_range(0, 9) < 8) ? sizes[$urandom_range(0, 3)] : sizes[$urandom_range(4, 5)];
      int off = $urandom_range(0, 15);
      int nb = 1 << int'(sz);
      logic [39:0] a;
      if (sz <= 3'd3 && $urandom_range(0, 4) != 0) off = off - (off % nb);
      a = 40'(longint'($urandom_range(0, 3)) * MEM_ELS * 16 + longint'($urandom_range(0, 7)) * 16 + off);
      do_txn(rq, sz, a, {$urandom, $urandom}, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    bit resp, ok;
    ref_req(STORE_RQ, 3'd3, 40'h200, 64'h0123456789ABCDEF, resp);
    send_req(STORE_RQ, 3'd3, 40'h200, 64'h0123456789ABCDEF, ok);
    rst_n = 1'b0;
    exp_q.delete(); exp_mask_q.delete(); exp_type_q.delete();
    exp_err = 1'b0; exp_ld = 0; exp_st = 0;
    #1;
    n_tests++;
    if (bus.l15_transducer_val !== 1'b0 || err !== 1'b0 || lc !== 16'h0 || sc !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid: val=%b err=%b lc=%0d sc=%0d required 0 0 0 0",
                         bus.l15_transducer_val, err, lc, sc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    take_int(0);
    do_txn(LOAD_RQ, 3'd3, 40'h200, 64'h0, 0);
    do_txn(LOAD_RQ, 3'd3, 40'h100, 64'h0, 1);
  endtask

  initial begin
    bus.transducer_l15_val      = 1'b0;
    bus.transducer_l15_rqtype   = '0;
    bus.transducer_l15_nc       = 1'b0;
    bus.transducer_l15_size     = '0;
    bus.transducer_l15_address  = '0;
    bus.transducer_l15_data     = '0;
    bus.transducer_l15_l1rplway = '0;
    bus.transducer_l15_req_ack  = 1'b0;
    test_reset();
    test_store_load();
    test_byte_store();
    test_misaligned();
    test_alias_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
